debounce_filter: RTL

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

---
 rtl/debounce_filter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/debounce_filter.sv
// Multi-channel input debouncer: optional synchroniser, optional polarity
// inversion, prescaled sampling into a per-channel history register, and a
// filtered output that only changes after Number equal consecutive samples.
// Rise/Fall/Changed are one-clock pulses aligned with the new level on O.
module debounce_filter #(
    parameter int               Size            = 4,
    parameter int               Number          = 4,
    parameter int               ClockPeriod_ns  = 20,
    parameter int               FilterPeriod_ns = 500_000,
    parameter int               SyncStages      = 2,
    parameter logic [Size-1:0]  Invert          = '0,
    parameter logic [Size-1:0]  InitValue       = '1
) (
    input  logic            Clock,
    input  logic            nReset,
    input  logic            Enable,
    input  logic [Size-1:0] I,
    output logic [Size-1:0] O,
    output logic [Size-1:0] Rise,
    output logic [Size-1:0] Fall,
    output logic            Changed
);

    localparam int Prescale = FilterPeriod_ns / ClockPeriod_ns / (Number - 1);

    logic            tick;
    logic [Size-1:0] sync_out;
    logic [Size-1:0] s_p0;
    logic [Number-1:0] hist_p1 [Size];
    logic [Size-1:0] o_nxt;
    logic [Size-1:0] rise_nxt;
    logic [Size-1:0] fall_nxt;

    // ---- sampling strobe ----
    generate
        if (Prescale <= 1) begin : g_no_prescale
            assign tick = Enable;
        end else begin : g_prescale
            localparam int              CountW = $clog2(Prescale);
            localparam logic [CountW-1:0] Last = CountW'(Prescale - 1);
            logic [CountW-1:0] count;

            // Prescaler counts enabled cycles and wraps after the strobe.
            always_ff @(posedge Clock) begin
                if (!nReset) begin
                    count <= '0;
                end else if (Enable) begin
                    if (count == Last) count <= '0;
                    else               count <= count + 1'b1;
                end
            end

            assign tick = Enable && (count == Last);
        end
    endgenerate

    // ---- synchroniser: free-running, independent of Enable ----
    generate
        if (SyncStages == 0) begin : g_no_sync
            assign sync_out = I;
        end else begin : g_sync
            logic [Size-1:0] sync_p [SyncStages];

            // Metastability chain; reset value makes the sampled level equal InitValue.
            always_ff @(posedge Clock) begin
                if (!nReset) begin
                    for (int k = 0; k < SyncStages; k++) sync_p[k] <= InitValue ^ Invert;
                end else begin
                    sync_p[0] <= I;
                    for (int k = 1; k < SyncStages; k++) sync_p[k] <= sync_p[k-1];
                end
            end

            assign sync_out = sync_p[SyncStages-1];
        end
    endgenerate

    assign s_p0 = sync_out ^ Invert;

    // ---- history register (stage p1) ----
    // Shift the sampled level in at the LSB on every strobe.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            for (int i = 0; i < Size; i++) hist_p1[i] <= {Number{InitValue[i]}};
        end else if (tick) begin
            for (int i = 0; i < Size; i++) hist_p1[i] <= {hist_p1[i][Number-2:0], s_p0[i]};
        end
    end

    // Accept a new level only when the whole pre-shift history agrees with it.
    always_comb begin
        o_nxt    = O;
        rise_nxt = '0;
        fall_nxt = '0;
        if (tick) begin
            for (int i = 0; i < Size; i++) begin
                if ((hist_p1[i] == '0) && O[i]) begin
                    o_nxt[i]    = 1'b0;
                    fall_nxt[i] = 1'b1;
                end else if ((&hist_p1[i]) && !O[i]) begin
                    o_nxt[i]    = 1'b1;
                    rise_nxt[i] = 1'b1;
                end
            end
        end
    end

    // ---- output stage (p2) ----
    // Register filtered level together with its edge pulses.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            O       <= InitValue;
            Rise    <= '0;
            Fall    <= '0;
            Changed <= 1'b0;
        end else begin
            O       <= o_nxt;
            Rise    <= rise_nxt;
            Fall    <= fall_nxt;
            Changed <= |(rise_nxt | fall_nxt);
        end
    end

endmodule
